// File: rtl/adc_cmd_frame_tx_if.sv
// adc_cmd_frame_tx_if
// Bundles the request/config inputs and the command-stream outputs of the
// ADC command frame encoder.
//   slave  : the encoder (takes requests and config, drives the stream)
//   master : the host side (issues requests, consumes the stream)
// Signals:
//   i_send_req/i_send_type      one-cycle send request and frame type (1..5)
//   i_cfg_chnnel/speed/enable/trig  payload sources, sampled on acceptance
//   i_cmd_ready                 downstream ready
//   o_cmd_data/len/last/valid   byte stream with constant per-frame length
//   o_busy/o_done/o_req_err     frame status and request rejection pulse
interface adc_cmd_frame_tx_if;
  logic        i_send_req;
  logic [7:0]  i_send_type;
  logic [7:0]  i_cfg_chnnel;
  logic [23:0] i_cfg_speed;
  logic        i_cfg_enable;
  logic        i_cfg_trig;
  logic        i_cmd_ready;
  logic [7:0]  o_cmd_data;
  logic [7:0]  o_cmd_len;
  logic        o_cmd_last;
  logic        o_cmd_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_req_err;

  modport slave (
    input  i_send_req, i_send_type, i_cfg_chnnel, i_cfg_speed,
           i_cfg_enable, i_cfg_trig, i_cmd_ready,
    output o_cmd_data, o_cmd_len, o_cmd_last, o_cmd_valid,
           o_busy, o_done, o_req_err
  );

  modport master (
    output i_send_req, i_send_type, i_cfg_chnnel, i_cfg_speed,
           i_cfg_enable, i_cfg_trig, i_cmd_ready,
    input  o_cmd_data, o_cmd_len, o_cmd_last, o_cmd_valid,
           o_busy, o_done, o_req_err
  );
endinterface

// File: rtl/adc_cmd_frame_tx.sv
// adc_cmd_frame_tx
// Serialises one ADC command frame per accepted request:
//   head, type, payload length, payload bytes (1 or 3).
// All outputs are registered; a byte moves on valid & ready and the stream
// holds while ready is low.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (aborts any frame in flight)
//   bus      adc_cmd_frame_tx_if.slave: request/config in, stream/status out
module adc_cmd_frame_tx #(
  parameter logic [7:0] P_HEAD      = 8'h55,
  parameter logic [7:0] P_SEEK_BYTE = 8'h01
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  adc_cmd_frame_tx_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_TYPE,
    S_LEN,
    S_PAY
  } state_t;

  state_t          r_state, w_state_nxt;

  // Frame contents captured at acceptance; entry 3 is never populated and
  // only exists so the next-byte index never falls outside the array.
  logic [7:0]      r_type;
  logic [7:0]      r_len;
  logic [3:0][7:0] r_pay;
  logic [1:0]      r_idx, w_idx_nxt;

  logic [7:0]      r_data,  w_data_nxt;
  logic            r_last,  w_last_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_busy,  w_busy_nxt;
  logic            r_done,  w_done_nxt;
  logic            r_err,   w_err_nxt;

  logic            w_type_ok;
  logic            w_accept;
  logic            w_xfer;
  logic [7:0]      w_new_len;
  logic [3:0][7:0] w_new_pay;
  logic [1:0]      w_idx_inc;

  // Payload build from the live config inputs; only used on acceptance.
  always_comb begin
    w_type_ok = (bus.i_send_type >= 8'd1) && (bus.i_send_type <= 8'd5);
    w_new_len = 8'd1;
    w_new_pay = '0;
    case (bus.i_send_type)
      8'd1: w_new_pay[0] = bus.i_cfg_chnnel;
      8'd2: begin
        w_new_len    = 8'd3;
        w_new_pay[0] = bus.i_cfg_speed[23:16];
        w_new_pay[1] = bus.i_cfg_speed[15:8];
        w_new_pay[2] = bus.i_cfg_speed[7:0];
      end
      8'd3: w_new_pay[0] = {7'b0, bus.i_cfg_enable};
      8'd4: w_new_pay[0] = {7'b0, bus.i_cfg_trig};
      8'd5: w_new_pay[0] = P_SEEK_BYTE;
      default: ;
    endcase
  end

  assign w_accept  = bus.i_send_req && (r_state == S_IDLE) && w_type_ok;
  assign w_xfer    = r_valid && bus.i_cmd_ready;
  assign w_idx_inc = r_idx + 2'd1;

  // Next state and next registered outputs. Data/last only change on a
  // transfer (or on acceptance), which gives the hold-while-stalled rule.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    // Any request that is not accepted is an error: busy or illegal type.
    w_err_nxt   = bus.i_send_req && !w_accept;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_HEAD;
          w_data_nxt  = P_HEAD;
          w_last_nxt  = 1'b0;
          w_valid_nxt = 1'b1;
        end
      end
      S_HEAD: begin
        if (w_xfer) begin
          w_state_nxt = S_TYPE;
          w_data_nxt  = r_type;
        end
      end
      S_TYPE: begin
        if (w_xfer) begin
          w_state_nxt = S_LEN;
          w_data_nxt  = r_len;
        end
      end
      S_LEN: begin
        if (w_xfer) begin
          w_state_nxt = S_PAY;
          w_data_nxt  = r_pay[0];
          w_idx_nxt   = 2'd0;
          w_last_nxt  = (r_len == 8'd1);
        end
      end
      S_PAY: begin
        if (w_xfer) begin
          if (r_last) begin
            w_state_nxt = S_IDLE;
            w_data_nxt  = 8'd0;
            w_last_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_data_nxt = r_pay[w_idx_inc];
            // last lands on payload byte len-1
            w_last_nxt = (({6'd0, w_idx_inc} + 8'd1) == r_len);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_type  <= '0;
      r_len   <= '0;
      r_pay   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_type <= bus.i_send_type;
        r_len  <= w_new_len;
        r_pay  <= w_new_pay;
      end
    end
  end

  assign bus.o_cmd_data  = r_data;
  assign bus.o_cmd_len   = r_len;
  assign bus.o_cmd_last  = r_last;
  assign bus.o_cmd_valid = r_valid;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_req_err   = r_err;

endmodule

// File: doc/adc_cmd_frame_tx.md
Name: adc_cmd_frame_tx

Overview:
Frame encoder for the ADC command byte stream: the transmit end of the protocol the ADC control decoder consumes. On a send request it serialises one command frame into the stream:
- byte0 head
- byte1 control type
- byte2 payload length
- bytes 3..2+len payload

It sits between the host-side configuration source (register bank / test sequencer) and the command channel feeding the ADC controller. It emits type 1..5 frames: channel count, sample speed, enable, trigger mode, seek.

Parameters:
P_HEAD, 8'h55, value placed in byte0 of every frame
P_SEEK_BYTE, 8'h01, payload byte sent for a type-5 (seek) frame

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_send_req  input  1  single-cycle request to send one frame
i_send_type  input  8  control type for the request, legal 1..5
i_cfg_chnnel  input  8  channel count payload (type 1)
i_cfg_speed  input  24  sample speed payload (type 2), sent MSB byte first
i_cfg_enable  input  1  enable payload (type 3), zero-extended to 8 bits
i_cfg_trig  input  1  trigger payload (type 4), zero-extended to 8 bits
i_cmd_ready  input  1  downstream ready; tie 1 when driving the ADC controller directly
o_cmd_data  output  8  stream byte
o_cmd_len  output  8  payload length of current frame, constant for the whole frame
o_cmd_last  output  1  marks final byte of frame
o_cmd_valid  output  1  byte valid
o_busy  output  1  frame in progress (request accepted, last byte not yet accepted)
o_done  output  1  one-cycle pulse the cycle after the last byte is accepted
o_req_err  output  1  one-cycle pulse: request rejected (busy or illegal type)

Behaviour:
- Reset (i_rst_n low, async): all outputs 0. State IDLE. Latched type, length and payload registers 0. Reset mid-frame aborts immediately: valid drops with no last byte, and no done pulse follows.
- All outputs are registered.
- Byte transfer: a byte is accepted on any cycle with o_cmd_valid & i_cmd_ready. While valid & !ready, o_cmd_data, o_cmd_len and o_cmd_last hold stable.
- Request acceptance:
  - A request is accepted only when i_send_req=1, state IDLE, and i_send_type is 1..5.
  - On acceptance, the type, length and payload bytes are latched from the i_cfg_* inputs in that same cycle. Later input changes do not affect the frame.
- Payload per type:
  - Type 1: len 1, payload = chnnel.
  - Type 2: len 3, payload = speed[23:16], speed[15:8], speed[7:0].
  - Type 3: len 1, payload = {7'b0, enable}.
  - Type 4: len 1, payload = {7'b0, trig}.
  - Type 5: len 1, payload = P_SEEK_BYTE.
- Request errors:
  - i_send_req while busy (including the cycle o_done is high? no: o_done cycle is IDLE) -> o_req_err pulses 1 cycle later; the current frame is unaffected.
  - Type 0 or >5 -> o_req_err pulse; nothing is sent.
- State machine:
  - IDLE -> HEAD on accept. o_busy and o_cmd_valid rise the next cycle with data=P_HEAD.
  - HEAD -> TYPE on accept; data=type.
  - TYPE -> LEN on accept; data=len.
  - LEN -> PAY on accept; data = payload byte 0.
  - PAY: byte counter advances on each accept. o_cmd_last=1 exactly on payload byte len-1.
  - PAY -> IDLE on accept of the last byte. That same cycle valid, last and busy drop, and o_done pulses. The next request is accepted the cycle after.
- Latency with ready held high: request at cycle N -> head at N+1 -> last byte at N+3+len -> o_done at N+4+len.
- Frame size: type 2 is 6 bytes; all other types are 4 bytes.
- o_cmd_valid stays continuous within a frame when ready=1; no bubbles are inserted.

Test Plan:
- Ready=1; request type 1 with chnnel=8'h08 -> stream 55,01,01,08. len=1 on all bytes. last only on 08. o_done 1 cycle after. busy high for 4 cycles.
- Ready=1; request type 2 with speed=24'h0186A0 -> 55,02,03,01,86,A0. last on A0. Change i_cfg_speed mid-frame; frame bytes are unchanged.
- Type 3 enable=1 with ready toggling 1,0,0,1,...; then type 5 -> first frame 55,03,01,01. Bytes hold during ready=0. Second frame 55,05,01,01.
- Request type 4 during a type-2 frame -> o_req_err pulse. Type-2 frame completes intact; no type-4 frame sent. Request type 7 when idle -> o_req_err, valid stays 0.
- Back-to-back: request on the o_done cycle -> accepted; head of the second frame appears on the next cycle.
- Assert i_rst_n low during the payload of a type-2 frame -> all outputs 0 asynchronously, no o_done. After release, a new type-1 request sends a clean frame.
